// File: rtl/irq_dma_mr.sv
// irq_dma_mr: multi-region IRQ/DMA execution monitor.
// Each executable region runs its own EXEC/ABORT state machine. A region
// enters EXEC only on a clean entry at its first address. It falls back to
// ABORT on any interrupt or DMA activity while executing inside it, or on a
// DMA write that targets it. A shared saturating counter and a cause register
// record the abort events.
module irq_dma_mr #(
  parameter int ADDR_W       = 16,
  parameter int NUM_ER       = 2,
  parameter int CNT_W        = 8,
  parameter bit DMA_ADDR_CHK = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     irq,
  input  logic                     dma_en,
  input  logic [ADDR_W-1:0]        dma_addr,
  input  logic [NUM_ER*ADDR_W-1:0] er_min,
  input  logic [NUM_ER*ADDR_W-1:0] er_max,
  input  logic                     clr,
  output logic [NUM_ER-1:0]        exec,
  output logic [CNT_W-1:0]         abort_cnt,
  output logic [1:0]               abort_cause
);

  typedef enum logic {
    ST_ABORT = 1'b0,
    ST_EXEC  = 1'b1
  } state_e;

  state_e              state_q [NUM_ER];
  state_e              state_d [NUM_ER];
  logic [NUM_ER-1:0]   exec_q, exec_d;
  logic [CNT_W-1:0]    abort_cnt_q, abort_cnt_d;
  logic [1:0]          abort_cause_q, abort_cause_d;

  logic [NUM_ER-1:0]   valid_s;
  logic [NUM_ER-1:0]   in_er_s;
  logic [NUM_ER-1:0]   fst_s;
  logic [NUM_ER-1:0]   dma_hit_s;
  logic [NUM_ER-1:0]   viol_s;
  logic                ev_s;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Region decode: validity, pc inside region, entry point hit, DMA target hit, violation.
  always_comb begin
    valid_s   = '0;
    in_er_s   = '0;
    fst_s     = '0;
    dma_hit_s = '0;
    viol_s    = '0;
    for (int i = 0; i < NUM_ER; i++) begin
      valid_s[i]   = (er_min[i*ADDR_W +: ADDR_W] <= er_max[i*ADDR_W +: ADDR_W]);
      in_er_s[i]   = valid_s[i] &&
                     (pc >= er_min[i*ADDR_W +: ADDR_W]) &&
                     (pc <= er_max[i*ADDR_W +: ADDR_W]);
      fst_s[i]     = valid_s[i] && (pc == er_min[i*ADDR_W +: ADDR_W]);
      dma_hit_s[i] = DMA_ADDR_CHK && dma_en && valid_s[i] &&
                     (dma_addr >= er_min[i*ADDR_W +: ADDR_W]) &&
                     (dma_addr <= er_max[i*ADDR_W +: ADDR_W]);
      viol_s[i]    = (in_er_s[i] && (irq || dma_en)) || dma_hit_s[i];
    end
  end

  // Per-region next state; an abort event is a violation seen while in EXEC.
  always_comb begin
    ev_s   = 1'b0;
    exec_d = '0;
    for (int i = 0; i < NUM_ER; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_EXEC: begin
          if (viol_s[i]) begin
            state_d[i] = ST_ABORT;
            ev_s       = 1'b1;
          end else begin
            state_d[i] = ST_EXEC;
          end
        end
        ST_ABORT: begin
          if (fst_s[i] && !viol_s[i]) begin
            state_d[i] = ST_EXEC;
          end else begin
            state_d[i] = ST_ABORT;
          end
        end
        default: begin
          state_d[i] = ST_ABORT;
        end
      endcase
      exec_d[i] = (state_d[i] == ST_EXEC);
    end
  end

  // Abort counter and cause; an event wins over clear and counts once per cycle.
  always_comb begin
    abort_cnt_d   = abort_cnt_q;
    abort_cause_d = abort_cause_q;
    if (ev_s) begin
      abort_cause_d = {dma_en, irq};
      if (clr) begin
        abort_cnt_d = CNT_ONE;
      end else if (abort_cnt_q == CNT_MAX) begin
        abort_cnt_d = CNT_MAX;
      end else begin
        abort_cnt_d = abort_cnt_q + CNT_ONE;
      end
    end else if (clr) begin
      abort_cnt_d   = '0;
      abort_cause_d = 2'b00;
    end else begin
      abort_cnt_d   = abort_cnt_q;
      abort_cause_d = abort_cause_q;
    end
  end

  // State, exec flags and reporting registers; reset forces every region to ABORT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ER; i++) begin
        state_q[i] <= ST_ABORT;
      end
      exec_q        <= '0;
      abort_cnt_q   <= '0;
      abort_cause_q <= 2'b00;
    end else begin
      for (int i = 0; i < NUM_ER; i++) begin
        state_q[i] <= state_d[i];
      end
      exec_q        <= exec_d;
      abort_cnt_q   <= abort_cnt_d;
      abort_cause_q <= abort_cause_d;
    end
  end

  assign exec        = exec_q;
  assign abort_cnt   = abort_cnt_q;
  assign abort_cause = abort_cause_q;

endmodule

// File: tb/tb_irq_dma_mr.sv
// Directed self-checking bench for irq_dma_mr. Three instances share the
// stimulus: default parameters, DMA address check disabled, and a 2-bit counter.
module tb_irq_dma_mr;

  localparam int ADDR_W = 16;
  localparam int NUM_ER = 2;

  logic                     clk;
  logic                     reset;
  logic [ADDR_W-1:0]        pc;
  logic                     irq;
  logic                     dma_en;
  logic [ADDR_W-1:0]        dma_addr;
  logic [NUM_ER*ADDR_W-1:0] er_min;
  logic [NUM_ER*ADDR_W-1:0] er_max;
  logic                     clr;

  logic [NUM_ER-1:0] exec_a, exec_b, exec_c;
  logic [7:0]        cnt_a, cnt_b;
  logic [1:0]        cnt_c;
  logic [1:0]        cause_a, cause_b, cause_c;

  int tests_run;
  int tests_failed;

  irq_dma_mr #(.ADDR_W(ADDR_W), .NUM_ER(NUM_ER), .CNT_W(8), .DMA_ADDR_CHK(1'b1)) u_dut (
    .clk(clk), .reset(reset), .pc(pc), .irq(irq), .dma_en(dma_en), .dma_addr(dma_addr),
    .er_min(er_min), .er_max(er_max), .clr(clr),
    .exec(exec_a), .abort_cnt(cnt_a), .abort_cause(cause_a)
  );

  irq_dma_mr #(.ADDR_W(ADDR_W), .NUM_ER(NUM_ER), .CNT_W(8), .DMA_ADDR_CHK(1'b0)) u_nochk (
    .clk(clk), .reset(reset), .pc(pc), .irq(irq), .dma_en(dma_en), .dma_addr(dma_addr),
    .er_min(er_min), .er_max(er_max), .clr(clr),
    .exec(exec_b), .abort_cnt(cnt_b), .abort_cause(cause_b)
  );

  irq_dma_mr #(.ADDR_W(ADDR_W), .NUM_ER(NUM_ER), .CNT_W(2), .DMA_ADDR_CHK(1'b1)) u_sat (
    .clk(clk), .reset(reset), .pc(pc), .irq(irq), .dma_en(dma_en), .dma_addr(dma_addr),
    .er_min(er_min), .er_max(er_max), .clr(clr),
    .exec(exec_c), .abort_cnt(cnt_c), .abort_cause(cause_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b1;
    pc       = 16'h0000;
    irq      = 1'b0;
    dma_en   = 1'b0;
    dma_addr = 16'h0000;
    clr      = 1'b0;
    er_min   = {16'hFFFF, 16'hE000};   // ER1 invalid for now
    er_max   = {16'h0000, 16'hE0FF};
    #1;
    check_eq("rst_exec", 32'(exec_a), 32'h0);
    check_eq("rst_cnt", 32'(cnt_a), 32'h0);
    check_eq("rst_cause", 32'(cause_a), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Inside the region without entering at min: no EXEC.
    pc = 16'hE010;
    tick();
    check_eq("mid_entry_exec", 32'(exec_a), 32'h0);

    // Clean entry at min.
    pc = 16'hE000;
    tick();
    check_eq("entry_exec", 32'(exec_a), 32'h1);

    pc = 16'hE050;
    tick();
    check_eq("hold_exec", 32'(exec_a), 32'h1);

    // IRQ while inside.
    pc  = 16'hE080;
    irq = 1'b1;
    tick();
    check_eq("irq_exec", 32'(exec_a), 32'h0);
    check_eq("irq_cnt", 32'(cnt_a), 32'd1);
    check_eq("irq_cause", 32'(cause_a), 32'h1);

    // Entry blocked by irq: no event.
    pc  = 16'hE000;
    irq = 1'b1;
    tick();
    check_eq("blocked_exec", 32'(exec_a), 32'h0);
    check_eq("blocked_cnt", 32'(cnt_a), 32'd1);
    irq = 1'b0;
    tick();
    check_eq("unblocked_exec", 32'(exec_a), 32'h1);

    // DMA targeting the region from outside.
    pc       = 16'hC000;
    dma_en   = 1'b1;
    dma_addr = 16'hE004;
    tick();
    check_eq("dma_hit_exec", 32'(exec_a), 32'h0);
    check_eq("dma_hit_cause", 32'(cause_a), 32'h2);
    check_eq("dma_hit_cnt", 32'(cnt_a), 32'd2);
    check_eq("nochk_exec", 32'(exec_b), 32'h1);
    check_eq("nochk_cnt", 32'(cnt_b), 32'd1);
    dma_en = 1'b0;

    // Overlapping regions aborted together, counted once.
    er_min = {16'hE000, 16'hE000};
    er_max = {16'hE01F, 16'hE0FF};
    pc     = 16'hE000;
    tick();
    check_eq("overlap_enter", 32'(exec_a), 32'h3);
    pc     = 16'hE010;
    dma_en = 1'b1;
    tick();
    check_eq("overlap_exec", 32'(exec_a), 32'h0);
    check_eq("overlap_cnt", 32'(cnt_a), 32'd3);
    check_eq("overlap_cause", 32'(cause_a), 32'h2);
    check_eq("sat_cnt3", 32'(cnt_c), 32'd3);
    dma_en = 1'b0;

    // Two more events: five in total.
    for (int k = 0; k < 2; k++) begin
      pc  = 16'hE000;
      irq = 1'b0;
      tick();
      pc  = 16'hE010;
      irq = 1'b1;
      tick();
    end
    irq = 1'b0;
    check_eq("sat_cnt5", 32'(cnt_c), 32'd3);
    check_eq("full_cnt5", 32'(cnt_a), 32'd5);

    // Clear together with an event.
    pc = 16'hE000;
    tick();
    pc  = 16'hE010;
    irq = 1'b1;
    clr = 1'b1;
    tick();
    check_eq("clr_ev_cnt", 32'(cnt_a), 32'd1);
    check_eq("clr_ev_sat", 32'(cnt_c), 32'd1);
    check_eq("clr_ev_cause", 32'(cause_a), 32'h1);

    // Clear alone.
    irq = 1'b0;
    pc  = 16'hC000;
    clr = 1'b1;
    tick();
    check_eq("clr_cnt", 32'(cnt_a), 32'd0);
    check_eq("clr_cause", 32'(cause_a), 32'h0);
    check_eq("clr_sat", 32'(cnt_c), 32'd0);
    clr = 1'b0;

    // Invalid region entered at its min.
    er_min = {16'hF000, 16'hE000};
    er_max = {16'hE000, 16'hE0FF};
    pc     = 16'hF000;
    tick();
    tick();
    check_eq("invalid_exec", 32'(exec_a), 32'h0);

    // Asynchronous reset while in EXEC.
    pc = 16'hE000;
    tick();
    check_eq("pre_areset_exec", 32'(exec_a), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("areset_exec", 32'(exec_a), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
